// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a program image over a UART line and writes it, one 32-bit word
//   at a time, into program memory while holding the CPU in reset.
//
//   Frame: 0xA5, count_lo, count_hi, count x 4 data bytes (little-endian per
//   word), then an optional checksum byte (sum mod 256 of all data bytes).
//
//   Optional feature macro: LOADER_CHECKSUM_EN (checksum byte checked in CHECK).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rx         asynchronous UART input, idle high
//   mem_we     write request to program memory (held until mem_ack)
//   mem_ack    memory accepted the current write
//   mem_addr   word address of the current write
//   mem_wdata  write data
//   busy       load in progress
//   done       last load succeeded
//   error      last load failed
//   cpu_hold   holds the CPU in reset, equals busy
//   state_dbg  current loader FSM state (debug observation)
//
// Memory handshake: mem_we, mem_addr and mem_wdata are stable from the cycle
// mem_we rises until the cycle mem_ack is sampled high; mem_we drops on the
// following cycle. An incoming byte during a pending write aborts the load.
module uart_boot_loader #(
  parameter int CLOCK_FREQ = 25000000,
  parameter int BIT_RATE   = 9600,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold,
  output logic [2:0]            state_dbg
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  // ---------------------------------------------------------------------
  // rx synchronizer; rx_prev gives the previous synchronized value for
  // start-edge detection.
  // ---------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t       rx_state, rx_state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic            byte_valid;
  logic            frame_err;

  always_comb begin
    rx_state_next = rx_state;
    cnt_next      = cnt + CW'(1);
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF_BIT - 1)) begin
          cnt_next      = '0;
          bit_idx_next  = 3'd0;
          // High at mid-start is a glitch: drop back to idle.
          rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next     = '0;
          shift_next   = {rx_sync, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next      = '0;
          rx_state_next = RX_IDLE;
          if (rx_sync) byte_valid = 1'b1;
          else         frame_err  = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      rx_state <= rx_state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
    end
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  state_t       state, state_next;
  logic [7:0]   len_lo;
  logic [15:0]  count;
  logic [15:0]  len_full;
  logic [16:0]  word_idx;    // words already accepted by memory
  logic [1:0]   byte_idx;    // byte position within the current word
  logic [23:0]  word_buf;    // first three bytes of the current word
  logic         sync_seen;
  logic         last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   csum;
`endif

  assign len_full  = {shift, len_lo};
  assign sync_seen = byte_valid && (shift == 8'hA5);
  assign last_word = (word_idx + 17'd1) == {1'b0, count};

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (sync_seen) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (frame_err)       state_next = ERROR;
        else if (byte_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (frame_err) state_next = ERROR;
        else if (byte_valid) begin
          if ({16'd0, len_full} > MAX_WORDS) state_next = ERROR;
          else if (len_full == 16'd0)        state_next = CHECK;
          else                               state_next = DATA;
        end
      end
      DATA: begin
        if (frame_err)                             state_next = ERROR;
        else if (byte_valid && byte_idx == 2'd3)   state_next = WRITE;
      end
      WRITE: begin
        // A byte arriving before the write is accepted means it was lost.
        if (frame_err || byte_valid) state_next = ERROR;
        else if (mem_ack)            state_next = last_word ? CHECK : DATA;
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (frame_err)       state_next = ERROR;
        else if (byte_valid) state_next = (shift == csum) ? DONE : ERROR;
`else
        state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_lo    <= 8'd0;
      count     <= 16'd0;
      word_idx  <= 17'd0;
      byte_idx  <= 2'd0;
      word_buf  <= 24'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE, ERROR: begin
          if (sync_seen) begin
            word_idx <= 17'd0;
            byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        LEN_LO: if (byte_valid) len_lo <= shift;
        LEN_HI: if (byte_valid) count  <= len_full;
        DATA: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {shift, word_buf[23:8]};
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum + shift;
`endif
            if (byte_idx == 2'd3) begin
              mem_addr  <= ADDR_WIDTH'(word_idx);
              mem_wdata <= {shift, word_buf};
            end
          end
        end
        WRITE: begin
          if (state_next != ERROR && mem_ack) word_idx <= word_idx + 17'd1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode straight from the registered state.
  assign mem_we    = (state == WRITE);
  assign busy      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) ||
                     (state == WRITE)  || (state == CHECK);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_hold  = busy;
  assign state_dbg = state;

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 The block SHALL provide parameter CLOCK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 The block SHALL provide parameter BIT_RATE, default 9600, UART bit rate; CLKS_PER_BIT = CLOCK_FREQ/BIT_RATE (integer division).
REQ-003 The block SHALL provide parameter ADDR_WIDTH, default 10, word-address width; capacity = 2^ADDR_WIDTH 32-bit words.
REQ-004 The block SHALL provide port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL provide port rx, input, 1, asynchronous UART serial input, idle high.
REQ-007 The block SHALL provide port mem_we, output, 1, write request to program memory.
REQ-008 The block SHALL provide port mem_ack, input, 1, memory accepted the current write.
REQ-009 The block SHALL provide port mem_addr, output, ADDR_WIDTH, word address of the current write.
REQ-010 The block SHALL provide port mem_wdata, output, 32, write data.
REQ-011 The block SHALL provide ports busy, done and error, each output, 1: load in progress, last load succeeded, last load failed.
REQ-012 The block SHALL provide port cpu_hold, output, 1, high to hold the CPU in reset; equals busy.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The receiver SHALL detect a start bit on a synchronized 1->0 edge, re-check low at CLKS_PER_BIT/2, then sample 8 data bits LSB-first and 1 stop bit, each CLKS_PER_BIT apart.
REQ-015 Start bit high at mid-sample SHALL be treated as a glitch and ignored; stop bit low SHALL be a framing error.
REQ-016 Frame format SHALL be: sync 0xA5, count low byte, count high byte, count x 4 data bytes (little-endian per word), then per REQ-030.
REQ-017 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-018 In IDLE, DONE and ERROR, a received 0xA5 SHALL enter LEN_LO, clear done/error, set busy; other bytes SHALL be ignored.
REQ-019 A count above 2^ADDR_WIDTH SHALL enter ERROR; a count of 0 SHALL go directly from LEN_HI to CHECK.
REQ-020 In DATA, the 4th byte of a word SHALL enter WRITE with mem_we=1, mem_addr = word index starting at 0, and mem_wdata = assembled word.
REQ-021 mem_we, mem_addr and mem_wdata SHALL hold stable until the cycle mem_ack=1; mem_we SHALL drop the next cycle, and the FSM SHALL return to DATA or, after the last word, go to CHECK.
REQ-022 A byte completing while in WRITE (overrun) SHALL enter ERROR, with mem_we deasserted immediately.
REQ-023 A framing error in any state other than IDLE/DONE/ERROR SHALL enter ERROR.
REQ-024 DONE SHALL set done=1, busy=0; ERROR SHALL set error=1, busy=0; both are held until the next 0xA5 or reset.
REQ-025 The word address SHALL never wrap; the last write uses address count-1.

Reset
REQ-026 On reset low, the block SHALL immediately set state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=0, and clear all counters and synchronizer flops to their idle values (synchronizer to 1).
REQ-027 Reset asserted mid-load SHALL abort without a further write; the partial memory contents are left as written.

Configuration
REQ-028 The macro LOADER_CHECKSUM_EN SHALL select checksum checking.
REQ-029 Without LOADER_CHECKSUM_EN, CHECK SHALL go to DONE in one cycle without receiving any byte.
REQ-030 With LOADER_CHECKSUM_EN, CHECK SHALL await one byte; if it equals the 8-bit sum mod 256 of all data bytes, the FSM SHALL go to DONE, otherwise to ERROR.

Verification
REQ-031 The bench SHALL send A5 02 00 11 22 33 44 55 66 77 88 (+ checksum 0x64 if enabled) with mem_ack one cycle after mem_we -> writes addr0=0x44332211 and addr1=0x88776655, then done=1, busy=0.
REQ-032 The bench SHALL send A5 00 00 (+ 00 if enabled) -> no mem_we, done=1.
REQ-033 With LOADER_CHECKSUM_EN, the bench SHALL send the REQ-031 frame with checksum 0x65 -> both words written, error=1, done=0.
REQ-034 With ADDR_WIDTH=2, the bench SHALL send A5 05 00 -> error=1 and no mem_we.
REQ-035 The bench SHALL hold mem_ack low past one byte time during a data load -> error=1 on the next byte and mem_we=0.
REQ-036 The bench SHALL pulse reset low during the 2nd word's bytes -> all outputs return to reset values, and a subsequent valid frame completes with done=1.
